elevator_call_queue: RTL and testbench
======================================

# elevator_call_queue

Request-side front end for the elevator controller. Accepts call requests (pickup floor, destination floor) from the hall/car panel logic, validates them, suppresses duplicates, and buffers them in a FIFO. Presents the oldest pending request to the controller through a valid/ready handshake. The controller dequeues one request each time it goes idle.

## Interface
Parameters:
- N, 10, queue depth in entries (2..15)
- TOP_FLOOR, 9, highest legal floor; floors are 1..TOP_FLOOR, and 0 (IDLE) means "no request"

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  panel offers a request this cycle
- req_from  in  4  pickup floor
- req_to  in  4  destination floor
- req_ready  out  1  queue can take a request (count < N); registered, no combinational path from inputs
- out_valid  out  1  head entry is present
- out_from  out  4  head pickup floor; IDLE when empty
- out_to  out  4  head destination floor; IDLE when empty
- out_ready  in  1  controller consumes head this cycle
- count  out  4  entries stored
- rej_pulse  out  1  one-cycle pulse: offered request was illegal or was offered while full
- dup_pulse  out  1  one-cycle pulse: offered request was dropped as a duplicate

## Operation
- Push occurs when req_valid & req_ready & legal & !dup.
- A request is legal when both floors are in 1..TOP_FLOOR and from != to.
- A request is illegal if either floor is 0, either floor is > TOP_FLOOR, or from == to. Illegal requests are dropped and raise rej_pulse.
- req_valid while !req_ready: the request is dropped and rej_pulse is raised. The panel is expected to hold and retry, so the drop is visible only through the pulse.
- Duplicate detection:
  - A request is a duplicate if an identical (from, to) pair is stored in any valid entry.
  - The head being popped in the same cycle is excluded from the comparison, so a re-request of a just-served call is accepted.
  - A duplicate is dropped, raises dup_pulse, and leaves count unchanged.
  - If a request is both illegal and a duplicate, it is counted as illegal: only rej_pulse is raised.
- Pop occurs when out_valid & out_ready. The head advances and the next entry becomes the head.
- Storage is a circular buffer with wr_ptr and rd_ptr (0..N-1, wrapping N-1 -> 0) plus count (0..N).
- Output ordering is FIFO. Duplicate suppression does not reorder entries.
- out_valid = (count != 0). out_from/out_to are driven from the head entry, or IDLE when count == 0.

## Timing
- Reset values:
  - count = 0, wr_ptr = rd_ptr = 0, all entries = IDLE
  - req_ready = 1, out_valid = 0, out_from = out_to = 0
  - rej_pulse = dup_pulse = 0
- Push latency: a request accepted at edge k appears at the outputs after edge k when the queue was empty (out_valid = 1 in cycle k+1). There is no same-cycle fall-through.
- Pop: out_ready sampled at edge k; the new head (or IDLE) is visible after edge k.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full (count == N), req_ready = 0, so a simultaneous push is rejected even though a pop frees a slot. req_ready reflects count from the previous edge.
- out_ready while empty: ignored; no pointer movement and no pulse.
- Pulses are registered and are high for exactly the cycle after the offending edge.
- count saturates at N and never underflows.
- Asserting rst mid-operation clears all state immediately, independent of clk. Pending requests are lost and the outputs go to their reset values without waiting for an edge.

## Test plan
- Reset, then push (4,1), (5,1), (2,5) on consecutive cycles with out_ready = 0 -> count = 3; out_from/out_to = 4/1 from cycle 2 onward; out_valid = 1.
- Pop the three entries with out_ready held high -> heads observed in order 4/1, 5/1, 2/5; then out_valid = 0, out_from = out_to = 0, count = 0.
- Push (3,6) twice; then (0,5), (7,7) and (12,2) with TOP_FLOOR = 9 -> one entry stored; dup_pulse once; rej_pulse three times; count = 1.
- Fill to N = 10 with distinct legal pairs; offer an 11th with out_ready = 1 in the same cycle -> 11th is rejected (rej_pulse), pop occurs, count = 9; req_ready returns to 1 in the next cycle. Verify pointer wrap by then pushing 10 more and popping all in FIFO order.
- Head (4,1) being popped while (4,1) is offered -> the request is accepted, no dup_pulse, and count is unchanged.
- Assert rst asynchronously mid-sequence with count = 5 -> all outputs reach their reset values before the next posedge; a subsequent push behaves as on an empty queue.

Source files
------------

// File: rtl/elevator_call_queue.sv
// ---------------------------------------------------------------------------
// elevator_call_queue
//
// Request-side front end for the elevator controller. Validates incoming
// (pickup, destination) call requests, drops illegal ones and duplicates of
// requests already pending, and buffers the rest in a circular FIFO. The
// oldest pending request is presented to the controller via valid/ready.
//
// Parameters:
//   N          queue depth in entries (2..15)
//   TOP_FLOOR  highest legal floor; legal floors are 1..TOP_FLOOR, 0 = IDLE
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   req_valid  panel offers a request this cycle
//   req_from   pickup floor
//   req_to     destination floor
//   req_ready  registered: queue can accept (count < N)
//   out_valid  head entry present
//   out_from   head pickup floor, IDLE when empty
//   out_to     head destination floor, IDLE when empty
//   out_ready  controller consumes the head this cycle
//   count      number of stored entries
//   rej_pulse  one-cycle pulse: request illegal or offered while full
//   dup_pulse  one-cycle pulse: request dropped as a duplicate
// ---------------------------------------------------------------------------
module elevator_call_queue #(
    parameter int N         = 10,
    parameter int TOP_FLOOR = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [3:0] req_from,
    input  logic [3:0] req_to,
    output logic       req_ready,
    output logic       out_valid,
    output logic [3:0] out_from,
    output logic [3:0] out_to,
    input  logic       out_ready,
    output logic [3:0] count,
    output logic       rej_pulse,
    output logic       dup_pulse
);

    localparam int              PW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0]      TOP  = 4'(TOP_FLOOR);
    localparam logic [3:0]      CAP  = 4'(N);
    localparam logic [PW-1:0]   LAST = PW'(N - 1);

    logic [3:0]    r_mem_from [N];
    logic [3:0]    r_mem_to   [N];
    logic [N-1:0]  r_vld;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [3:0]    r_count;
    logic          r_req_ready;
    logic          r_rej;
    logic          r_dup;

    logic          w_legal;
    logic          w_pop;
    logic          w_hit;
    logic          w_push;
    logic          w_rej;
    logic          w_dup;
    logic [3:0]    w_count_nxt;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_legal = (req_from != 4'd0) && (req_from <= TOP) &&
                     (req_to   != 4'd0) && (req_to   <= TOP) &&
                     (req_from != req_to);

    assign w_pop = (r_count != 4'd0) && out_ready;

    // Per-entry valid bits let the duplicate search ignore stale slots
    // without pointer arithmetic. The head being popped this cycle is
    // excluded so a call that is just being served can be re-requested.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_vld[i] &&
                (r_mem_from[i] == req_from) &&
                (r_mem_to[i] == req_to) &&
                !(w_pop && (r_rd_ptr == PW'(i)))) begin
                w_hit = 1'b1;
            end
        end
    end

    // Illegal/full takes precedence over duplicate for pulse reporting.
    assign w_rej  = req_valid && (!w_legal || !r_req_ready);
    assign w_dup  = req_valid && r_req_ready && w_legal && w_hit;
    assign w_push = req_valid && r_req_ready && w_legal && !w_hit;

    // A push only happens below N and a pop only above 0, so the count
    // saturates and never underflows without extra guards.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 4'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_mem_from[i] <= 4'd0;
                r_mem_to[i]   <= 4'd0;
            end
            r_vld       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= 4'd0;
            r_req_ready <= 1'b1;
            r_rej       <= 1'b0;
            r_dup       <= 1'b0;
        end else begin
            // Push and pop never target the same slot: that would need
            // count == 0 (no pop) or count == N (no push).
            if (w_push) begin
                r_mem_from[r_wr_ptr] <= req_from;
                r_mem_to[r_wr_ptr]   <= req_to;
                r_vld[r_wr_ptr]      <= 1'b1;
                r_wr_ptr             <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= ptr_next(r_rd_ptr);
            end
            r_count     <= w_count_nxt;
            // Ready follows the count of the previous edge, so a pop on a
            // full queue does not open a slot until the next cycle.
            r_req_ready <= (w_count_nxt < CAP);
            r_rej       <= w_rej;
            r_dup       <= w_dup;
        end
    end

    assign req_ready = r_req_ready;
    assign out_valid = (r_count != 4'd0);
    assign out_from  = out_valid ? r_mem_from[r_rd_ptr] : 4'd0;
    assign out_to    = out_valid ? r_mem_to[r_rd_ptr]   : 4'd0;
    assign count     = r_count;
    assign rej_pulse = r_rej;
    assign dup_pulse = r_dup;

endmodule

// File: tb/tb_elevator_call_queue.sv
// Bench for elevator_call_queue: queue-based reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_elevator_call_queue;

    localparam int N   = 10;
    localparam int TOP = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_from;
    logic [3:0] req_to;
    logic       req_ready;
    logic       out_valid;
    logic [3:0] out_from;
    logic [3:0] out_to;
    logic       out_ready;
    logic [3:0] count;
    logic       rej_pulse;
    logic       dup_pulse;

    elevator_call_queue #(.N(N), .TOP_FLOOR(TOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_from  (req_from),
        .req_to    (req_to),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_from  (out_from),
        .out_to    (out_to),
        .out_ready (out_ready),
        .count     (count),
        .rej_pulse (rej_pulse),
        .dup_pulse (dup_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f;
        int t;
    } pair_t;

    pair_t q[$];
    int    exp_rej;
    int    exp_dup;
    int    total;
    int    bad;
    bit    chk_en;
    int    seen_rej;
    int    seen_dup;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_rej = 0;
        exp_dup = 0;
    endtask

    // Reference behaviour: a plain list of pending calls, oldest first.
    task automatic model_edge(input bit v, input int f, input int t, input bit o);
        bit ready;
        bit legal;
        bit pop;
        bit dup;
        ready = (q.size() < N);
        legal = (f >= 1) && (f <= TOP) && (t >= 1) && (t <= TOP) && (f != t);
        pop   = (q.size() > 0) && o;
        dup   = 1'b0;
        for (int i = (pop ? 1 : 0); i < q.size(); i++)
            if (q[i].f == f && q[i].t == t) dup = 1'b1;
        exp_rej = (v && (!legal || !ready)) ? 1 : 0;
        exp_dup = (v && ready && legal && dup) ? 1 : 0;
        if (pop) void'(q.pop_front());
        if (v && ready && legal && !dup) q.push_back('{f: f, t: t});
    endtask

    task automatic step(input bit v, input int f, input int t, input bit o);
        req_valid = v;
        req_from  = 4'(f);
        req_to    = 4'(t);
        out_ready = o;
        @(posedge clk);
        model_edge(v, f, t, o);
        #1;
        if (rej_pulse) seen_rej++;
        if (dup_pulse) seen_dup++;
        req_valid = 1'b0;
        req_from  = 4'd0;
        req_to    = 4'd0;
        out_ready = 1'b0;
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("m_count", int'(count), q.size());
            chk("m_out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
            chk("m_out_from", int'(out_from), (q.size() != 0) ? q[0].f : 0);
            chk("m_out_to", int'(out_to), (q.size() != 0) ? q[0].t : 0);
            chk("m_req_ready", int'(req_ready), (q.size() < N) ? 1 : 0);
            chk("m_rej_pulse", int'(rej_pulse), exp_rej);
            chk("m_dup_pulse", int'(dup_pulse), exp_dup);
        end
    end

    int ef[3] = '{4, 5, 2};
    int et[3] = '{1, 1, 5};
    int af[10];
    int at[10];
    int bf[10];
    int bt[10];

    initial begin
        total = 0; bad = 0; chk_en = 0;
        seen_rej = 0; seen_dup = 0;
        req_valid = 0; req_from = 0; req_to = 0; out_ready = 0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_from", int'(out_from), 0);
        chk("rst_out_to", int'(out_to), 0);
        chk("rst_pulses", int'(rej_pulse) + int'(dup_pulse), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Three pushes, no consumption.
        step(1, 4, 1, 0);
        chk("push1_valid", int'(out_valid), 1);
        chk("push1_head_from", int'(out_from), 4);
        step(1, 5, 1, 0);
        step(1, 2, 5, 0);
        chk("push3_count", int'(count), 3);
        chk("push3_head_to", int'(out_to), 1);

        // Drain in FIFO order.
        for (int i = 0; i < 3; i++) begin
            chk("pop_head_from", int'(out_from), ef[i]);
            chk("pop_head_to", int'(out_to), et[i]);
            step(0, 0, 0, 1);
        end
        chk("drained_valid", int'(out_valid), 0);
        chk("drained_from", int'(out_from), 0);
        chk("drained_count", int'(count), 0);

        // Duplicate and illegal requests.
        seen_rej = 0; seen_dup = 0;
        step(1, 3, 6, 0);
        step(1, 3, 6, 0);
        step(1, 0, 5, 0);
        step(1, 7, 7, 0);
        step(1, 12, 2, 0);
        chk("filter_count", int'(count), 1);
        chk("filter_dups", seen_dup, 1);
        chk("filter_rejs", seen_rej, 3);
        step(0, 0, 0, 1);

        // Fill to N with distinct pairs.
        for (int i = 0; i < N; i++) begin
            af[i] = (i < 9) ? i + 1 : 2;
            at[i] = (i < 9) ? (i + 1) % 9 + 1 : 4;
            step(1, af[i], at[i], 0);
        end
        chk("full_count", int'(count), 10);
        chk("full_ready", int'(req_ready), 0);
        seen_rej = 0;
        step(1, 5, 6, 1);
        chk("full_push_rej", seen_rej, 1);
        chk("full_pop_count", int'(count), 9);
        chk("ready_back", int'(req_ready), 1);

        // Push and pop together ten times, wrapping both pointers.
        for (int i = 0; i < N; i++) begin
            bf[i] = (i < 8) ? i + 2 : i - 5;
            bt[i] = (i < 8) ? 1 : 9;
            step(1, bf[i], bt[i], 1);
        end
        chk("wrap_count", int'(count), 9);
        for (int i = 1; i < N; i++) begin
            chk("wrap_head_from", int'(out_from), bf[i]);
            chk("wrap_head_to", int'(out_to), bt[i]);
            step(0, 0, 0, 1);
        end
        chk("wrap_empty", int'(out_valid), 0);

        // Re-request of the head being popped is accepted.
        step(1, 4, 1, 0);
        seen_dup = 0;
        step(1, 4, 1, 1);
        chk("rerequest_dup", seen_dup, 0);
        chk("rerequest_count", int'(count), 1);
        chk("rerequest_head", int'(out_from), 4);
        step(0, 0, 0, 1);

        // Asynchronous reset with five entries pending.
        step(1, 1, 2, 0);
        step(1, 2, 3, 0);
        step(1, 3, 4, 0);
        step(1, 4, 5, 0);
        step(1, 5, 6, 0);
        step(1, 0, 0, 0);
        chk("pre_rst_count", int'(count), 5);
        chk("pre_rst_rej", int'(rej_pulse), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_from", int'(out_from), 0);
        chk("arst_to", int'(out_to), 0);
        chk("arst_ready", int'(req_ready), 1);
        chk("arst_rej", int'(rej_pulse), 0);
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(1, 6, 2, 0);
        chk("post_rst_count", int'(count), 1);
        chk("post_rst_head", int'(out_from), 6);
        step(0, 0, 0, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
